fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and issue unit for the single-processor core. Requests 32-bit instruction words from instruction memory, holds each word on the opcode/instruction bus for the opcode decoder, and waits for the execute stage to accept it. The decoder's branch/jump/invertzero outputs and the ALU zero flag are fed back to form the next PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] forced to 0 on use
- HALT_OPCODE, 6'b111111, opcode that stops fetching after it is accepted

- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; high only in FETCH
- imem_addr  out  32  fetch address; equals pc while imem_req is high
- imem_ack  in  1  memory response strobe; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- instr  out  32  registered instruction word under issue
- opcode  out  6  instr[31:26], wired directly to the decoder opcode input
- pc  out  32  address of the instruction in instr
- instr_valid  out  1  instr/opcode/pc valid; high only in ISSUE
- instr_accept  in  1  execute stage consumed the instruction; sampled only in ISSUE
- branch, jump, invertzero  in  1 each  decoder outputs for the issued instruction
- zero  in  1  ALU zero flag for the issued instruction
- halted  out  1  high in HALT
- instr_count  out  32  number of accepted instructions, wraps modulo 2^32

## Operation
- Reset values: state IDLE, pc = RESET_PC & ~3, instr 0, instr_count 0. imem_req, instr_valid, and halted are 0.
- FSM states: IDLE, FETCH, ISSUE, HALT.
  - IDLE -> FETCH unconditionally on the next edge.
  - FETCH: drive imem_req=1 and imem_addr=pc. When imem_ack=1, capture imem_rdata into instr and go to ISSUE. Otherwise stay, with the request and address held stable.
  - ISSUE: drive instr_valid=1. When instr_accept=1, load the next pc, increment instr_count, and go to HALT if opcode==HALT_OPCODE, else to FETCH. Otherwise stay; instr and pc are held.
  - HALT: halted=1. No requests. Leave only via rst_n.
- imem_ack is ignored outside FETCH.
- instr_accept is ignored outside ISSUE.
- Next PC, evaluated at accept, where pc4 = pc + 4 (32-bit modular):
  - jump=1: {pc4[31:28], instr[25:0], 2'b00}.
  - Else, if branch=1 and (zero ^ invertzero)=1: pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Else: pc4.
- Priority is jump > taken branch > sequential. If jump and branch are both asserted, the result is the jump target.
- All PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 0. pc[1:0] is always 0.
- The halt instruction still updates pc and instr_count when it is accepted.

## Timing
- After rst_n rises: one IDLE cycle, then imem_req=1 on the second edge.
- Zero-wait memory (imem_ack in the first FETCH cycle) plus instr_accept in the first ISSUE cycle gives 2 cycles per instruction, the maximum throughput.
- Each cycle of memory wait or accept stall adds exactly one cycle.
- instr and instr_valid update on the edge that samples imem_ack; they are visible the following cycle.
- The redirect target is visible on imem_addr in the FETCH cycle immediately after the accept edge.
- rst_n low at any time, including mid-FETCH with a request outstanding or mid-ISSUE, immediately forces all reset values. A late imem_ack arriving during or after reset, before FETCH, is ignored.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0, zero-wait memory, instr_accept tied 1. Expect imem_addr 0, 4, 8 on successive FETCH cycles; instr_count=3 after the third accept; instr_valid toggles every cycle.
- **Memory wait:** imem_ack held low for 3 cycles. Expect imem_req and imem_addr held stable for 4 FETCH cycles; instr captures the word only on the ack cycle.
- **Branches:**
  - At pc=0x10, branch=1, zero=1, invertzero=0, imm=16'hFFFE. Expect next imem_addr = 0x0C.
  - Same instruction with invertzero=1. Expect 0x14.
- **Jump:** at pc=0x9000_0000, jump=1, instr[25:0]=26'h0000040, branch=1 also asserted. Expect next imem_addr = 0x9000_0100 (jump wins).
- **Stall and halt:**
  - instr_accept low for 5 ISSUE cycles: instr, pc, and opcode stay stable; no imem_req.
  - Issue opcode 6'b111111: after accept, halted=1 and imem_req stays 0 for 20 cycles.
- **Reset mid-operation and wrap:**
  - Assert rst_n=0 during FETCH, then pulse imem_ack. Expect all outputs at reset values and the first post-reset fetch at RESET_PC.
  - Sequential fetch from pc=0xFFFF_FFFC. Expect next imem_addr = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch and issue unit: fetches one word at a time, holds it for the
// decoder/execute stage, and computes the next PC from the decoder and ALU feedback.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        branch,
  input  logic        jump,
  input  logic        invertzero,
  input  logic        zero,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt
  } state_e;

  localparam logic [31:0] PcInit = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  // Jump beats a taken branch, which beats sequential flow.
  always_comb begin
    pc4    = pc_q + 32'd4;
    br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    end else if (branch && (zero ^ invertzero)) begin
      next_pc = pc4 + br_off;
    end else begin
      next_pc = pc4;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    count_d     = count_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (instr_accept) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = (instr_q[31:26] == HALT_OPCODE) ? StHalt : StFetch;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= PcInit;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: acts as a variable-latency memory and execute
// stage, and predicts PC/count per instruction from the branch/jump rules.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_accept;
  logic        branch;
  logic        jump;
  logic        invertzero;
  logic        zero;
  logic        halted;
  logic [31:0] instr_count;

  int          n_pass;
  int          n_total;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opcode       (opcode),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .branch       (branch),
    .jump         (jump),
    .invertzero   (invertzero),
    .zero         (zero),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Next PC straight from the architectural rules, using signed arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pcv, input logic [31:0] word,
                                             input logic b, input logic j, input logic z,
                                             input logic iz);
    logic [31:0] pc4;
    int          off;
    pc4 = pcv + 32'd4;
    off = $signed(word[15:0]);
    if (j) return {pc4[31:28], word[25:0], 2'b00};
    if (b && (z != iz)) return pc4 + 32'(off * 4);
    return pc4;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_count"}, instr_count, 32'd0);
  endtask

  // Entered and left at a negedge where the DUT is expected to be fetching.
  task automatic run_instr(input logic [31:0] word, input int wt, input int st, input logic b,
                           input logic j, input logic z, input logic iz);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < wt; i++) begin
      imem_ack     = 1'b0;
      imem_rdata   = $urandom;
      instr_accept = 1'($urandom);
      @(negedge clk);
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    imem_ack     = 1'b1;
    imem_rdata   = word;
    instr_accept = 1'($urandom);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("issue_valid", 32'(instr_valid), 32'd1);
    chk("issue_instr", instr, word);
    chk("issue_opcode", 32'(opcode), 32'(word[31:26]));
    chk("issue_pc", pc, m_pc);
    chk("issue_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < st; i++) begin
      instr_accept = 1'b0;
      imem_ack     = 1'($urandom);
      imem_rdata   = $urandom;
      branch       = 1'($urandom);
      jump         = 1'($urandom);
      zero         = 1'($urandom);
      invertzero   = 1'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, word);
      chk("stall_opcode", 32'(opcode), 32'(word[31:26]));
      chk("stall_pc", pc, m_pc);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_count", instr_count, m_count);
    end
    instr_accept = 1'b1;
    branch       = b;
    jump         = j;
    zero         = z;
    invertzero   = iz;
    m_pc         = model_next(m_pc, word, b, j, z, iz);
    m_count      = m_count + 32'd1;
    @(negedge clk);
    instr_accept = 1'b0;
    imem_ack     = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    zero         = 1'b0;
    invertzero   = 1'b0;
    chk("accept_count", instr_count, m_count);
    chk("accept_pc", pc, m_pc);
    chk("accept_valid", 32'(instr_valid), 32'd0);
    if (word[31:26] == 6'b111111) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
    end else begin
      chk("next_req", 32'(imem_req), 32'd1);
      chk("next_addr", imem_addr, m_pc);
      chk("next_halted", 32'(halted), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w;
    n_pass       = 0;
    n_total      = 0;
    m_pc         = 32'h0;
    m_count      = 32'h0;
    rst_n        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    instr_accept = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    invertzero   = 1'b0;
    zero         = 1'b0;

    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);

    // Sequential zero-wait fetch
    run_instr(32'h0000_0001, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0400_0002, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0800_0003, 0, 0, 0, 0, 0, 0);
    chk("seq_count3", instr_count, 32'd3);
    // Memory wait of 3 cycles
    run_instr(32'h1234_5678, 3, 0, 0, 0, 0, 0);
    // Branch at 0x10 taken back to 0x0C, then not taken with invertzero
    chk("br_pc", m_pc, 32'h10);
    run_instr(32'h1000_FFFE, 0, 0, 1, 0, 1, 0);
    chk("br_taken_addr", imem_addr, 32'h0000_000C);
    run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0);
    run_instr(32'h1000_FFFE, 0, 0, 1, 0, 1, 1);
    chk("br_nt_addr", imem_addr, 32'h0000_0014);
    // Jump with branch also asserted
    run_instr(32'h0800_0040, 0, 0, 1, 1, 1, 0);
    chk("jump_addr", imem_addr, 32'h0000_0100);
    // Accept stall of 5 cycles
    run_instr(32'h2C00_0011, 0, 5, 0, 0, 0, 0);
    // Branch to the top of the address space, then wrap sequentially to 0
    run_instr(32'h1000_FFBD, 1, 1, 1, 0, 0, 1);
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    run_instr(32'h0000_0000, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    run_instr(32'h0000_0000, 2, 0, 0, 0, 0, 0);

    // Reset mid-FETCH with a late ack around the release
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    m_pc     = 32'h0;
    m_count  = 32'h0;
    chk("rel_instr", instr, 32'd0);
    chk("rel_valid", 32'(instr_valid), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31:26] = 6'b000000;
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom));
    end

    // Halt instruction, then confirm no further requests
    run_instr(32'hFC00_0000, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      imem_ack     = 1'($urandom);
      instr_accept = 1'($urandom);
      @(negedge clk);
      chk("halt_hold_req", 32'(imem_req), 32'd0);
      chk("halt_hold_flag", 32'(halted), 32'd1);
      chk("halt_hold_valid", 32'(instr_valid), 32'd0);
    end
    chk("halt_final_count", instr_count, m_count);
    chk("halt_final_pc", pc, m_pc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
